// File: rtl/generate_ca_pkg.sv
// Shared constants for the CA history-register sequencer: state codes, counter width
// and operand-length clamping.
package generate_ca_pkg;

  localparam int unsigned CNT_W = 11;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // A zero-length request still needs one digit; longer ones cannot exceed the CA width.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] digits,
                                                 input logic [CNT_W-1:0] max_len);
    if (digits == '0) begin
      return CNT_W'(1);
    end else if (digits > max_len) begin
      return max_len;
    end
    return digits;
  endfunction

endpackage

// File: rtl/ca_addr_gen.sv
// Maps the digit counter onto CA RAM addresses and the CA left-shift amount.
module ca_addr_gen
  import generate_ca_pkg::*;
#(
  parameter int unsigned UNROLL     = 64,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic [CNT_W-1:0]      counter,
  input  logic                  active,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam logic [CNT_W-1:0] UnrollW = CNT_W'(UNROLL);

  always_comb begin
    wr_addr = counter[ADDR_WIDTH-1:0];
    // Read the slot written on the previous digit; the refresh digit reads slot 0.
    rd_addr = (counter == '0) ? '0 : wr_addr - ADDR_WIDTH'(1);
    shift_cnt = (active && (counter < UnrollW)) ? UnrollW - CNT_W'(1) - counter : '0;
  end

endmodule

// File: rtl/generate_ca_ctrl.sv
// Sequencer for the online-multiplier CA history register: accepts operand digits,
// pads the online delay with zero digits and flags valid output digits.
module generate_ca_ctrl
  import generate_ca_pkg::*;
#(
  parameter int unsigned UNROLL       = 64,
  parameter int unsigned ONLINE_DELAY = 3,
  parameter int unsigned ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  syn_reset_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_digits,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  enable,
  output logic                  refresh,
  output logic                  pad,
  output logic [CNT_W-1:0]      counter,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] OdW     = CNT_W'(ONLINE_DELAY);
  localparam logic [CNT_W-1:0] UnrollW = CNT_W'(UNROLL);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             running, draining;

  assign running  = (state_q == StRun);
  assign draining = (state_q == StDrain);
  assign cnt_inc  = counter_q + CNT_W'(1);

  always_comb begin
    in_ready  = running & in_valid;
    enable    = in_ready | draining;
    pad       = draining;
    refresh   = enable & (counter_q == '0);
    out_valid = enable & (counter_q >= OdW);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    counter   = counter_q;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    len_d     = len_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          counter_d = '0;
          len_d     = clamp_len(cfg_digits, UnrollW);
        end
      end
      StRun: begin
        if (in_valid) begin
          counter_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = (ONLINE_DELAY == 0) ? StDone : StDrain;
          end
        end
      end
      StDrain: begin
        counter_d = cnt_inc;
        if (cnt_inc == len_q + OdW) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      state_q   <= StIdle;
      counter_q <= '0;
      len_q     <= CNT_W'(1);
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      len_q     <= len_d;
    end
  end

  ca_addr_gen #(
    .UNROLL    (UNROLL),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .counter  (counter_q),
    .active   (busy),
    .shift_cnt(shift_cnt),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr)
  );

endmodule

// File: tb/tb_generate_ca_ctrl.sv
// Bench for generate_ca_ctrl: directed table, corner sequences and random stimulus
// against an operation-level reference model.
module tb_generate_ca_ctrl;

  localparam int UNROLL = 64;
  localparam int OD     = 3;
  localparam int AW     = 6;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          syn_reset_n, start, in_valid;
  logic [10:0]   cfg_digits;
  logic          in_ready, enable, refresh, pad, out_valid, busy, done;
  logic [10:0]   counter, shift_cnt;
  logic [AW-1:0] wr_addr, rd_addr;

  always #5 clk = ~clk;

  generate_ca_ctrl #(
    .UNROLL      (UNROLL),
    .ONLINE_DELAY(OD),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .syn_reset_n(syn_reset_n),
    .start      (start),
    .cfg_digits (cfg_digits),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enable     (enable),
    .refresh    (refresh),
    .pad        (pad),
    .counter    (counter),
    .shift_cnt  (shift_cnt),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Operation-level model: active covers the whole operation including its done cycle.
  bit m_active = 0;
  bit m_done   = 0;
  int m_n      = 0;
  int m_len    = 1;

  // Sampled DUT values and per-window statistics.
  logic        s_en, s_ref, s_pad, s_ov, s_busy, s_done;
  logic [10:0] s_cnt;
  int          n_en, n_ov, n_done;

  typedef struct {
    bit start;
    int cfg;
    bit valid;
    bit en;
    bit refr;
    bit pd;
    bit ov;
    int cnt;
    bit bsy;
    bit dn;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, name, act, exp);
    end
  endtask

  function automatic int clamp(input int c);
    if (c == 0) return 1;
    if (c > UNROLL) return UNROLL;
    return c;
  endfunction

  // Called at posedge+1; drives inputs, checks at negedge, advances model at posedge.
  task automatic step(input bit rst_n_v, input bit start_v, input int cfg_v, input bit valid_v);
    bit e_en, e_pad, e_rdy, e_ref, e_ov;
    int e_shift, e_wr, e_rd;
    syn_reset_n = rst_n_v;
    start       = start_v;
    cfg_digits  = 11'(cfg_v);
    in_valid    = valid_v;
    e_pad   = m_active && !m_done && (m_n >= m_len);
    e_rdy   = m_active && !m_done && (m_n < m_len) && valid_v;
    e_en    = e_pad || e_rdy;
    e_ref   = e_en && (m_n == 0);
    e_ov    = e_en && (m_n >= OD);
    e_shift = (m_active && m_n < UNROLL) ? UNROLL - 1 - m_n : 0;
    e_wr    = m_n % DEPTH;
    e_rd    = (m_n == 0) ? 0 : (m_n - 1) % DEPTH;
    @(negedge clk);
    chk("enable", 32'(enable), 32'(e_en));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("refresh", 32'(refresh), 32'(e_ref));
    chk("pad", 32'(pad), 32'(e_pad));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("counter", 32'(counter), 32'(m_n));
    chk("shift_cnt", 32'(shift_cnt), 32'(e_shift));
    chk("wr_addr", 32'(wr_addr), 32'(e_wr));
    chk("rd_addr", 32'(rd_addr), 32'(e_rd));
    s_en = enable; s_ref = refresh; s_pad = pad; s_ov = out_valid;
    s_busy = busy; s_done = done; s_cnt = counter;
    if (enable === 1'b1) n_en++;
    if (out_valid === 1'b1) n_ov++;
    if (done === 1'b1) n_done++;
    @(posedge clk);
    cyc++;
    if (!rst_n_v) begin
      m_active = 0; m_done = 0; m_n = 0; m_len = 1;
    end else if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (m_active) begin
      if (e_en) begin
        m_n++;
        if (m_n == m_len + OD) m_done = 1;
      end
    end else if (start_v) begin
      m_active = 1; m_n = 0; m_len = clamp(cfg_v);
    end
    #1;
  endtask

  task automatic clr_stats();
    n_en = 0; n_ov = 0; n_done = 0;
  endtask

  // Full-speed operation; expected counts come from the caller.
  task automatic run_op(input string name, input int cfg_v, input int exp_en, input int exp_ov);
    clr_stats();
    step(1, 1, cfg_v, 1);
    repeat (exp_en + 1) step(1, 0, 0, 1);
    chk({name, "_enables"}, 32'(n_en), 32'(exp_en));
    chk({name, "_out_valids"}, 32'(n_ov), 32'(exp_ov));
    chk({name, "_dones"}, 32'(n_done), 32'd1);
    step(1, 0, 0, 0);
  endtask

  initial begin
    bit stall_pat[9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};

    // start, cfg, valid | enable, refresh, pad, out_valid, counter, busy, done
    tbl[0] = '{1, 4, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    tbl[3] = '{0, 0, 1, 1, 0, 0, 0, 2, 1, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 0, 1, 3, 1, 0};
    tbl[5] = '{0, 0, 1, 1, 0, 1, 1, 4, 1, 0};
    tbl[6] = '{0, 0, 1, 1, 0, 1, 1, 5, 1, 0};
    tbl[7] = '{0, 0, 1, 1, 0, 1, 1, 6, 1, 0};
    tbl[8] = '{0, 0, 1, 0, 0, 0, 0, 7, 1, 1};
    tbl[9] = '{0, 0, 1, 0, 0, 0, 0, 7, 0, 0};

    syn_reset_n = 1'b0; start = 1'b0; cfg_digits = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 1, 5, 1);
    step(1, 0, 0, 1);

    // Basic 4-digit operation from the table.
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].start, tbl[i].cfg, tbl[i].valid);
      chk($sformatf("tbl%0d_vec", i),
          32'({s_en, s_ref, s_pad, s_ov, s_busy, s_done, s_cnt}),
          32'({tbl[i].en, tbl[i].refr, tbl[i].pd, tbl[i].ov, tbl[i].bsy, tbl[i].dn,
               11'(tbl[i].cnt)}));
    end

    // Two stall cycles after digit 1.
    clr_stats();
    step(1, 1, 4, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, stall_pat[i]);
    step(1, 0, 0, 0);
    chk("stall_enables", 32'(n_en), 32'd7);
    chk("stall_done_last", 32'(s_done), 32'd1);
    step(1, 0, 0, 0);

    // Length clamping and address wrap.
    run_op("len0", 0, 4, 1);
    run_op("len100", 100, 67, 64);
    run_op("len64", 64, 67, 64);

    // start held high while busy, then accepted right after done.
    clr_stats();
    step(1, 1, 4, 1);
    repeat (8) step(1, 1, 2, 1);
    chk("busy_start_enables", 32'(n_en), 32'd7);
    chk("busy_start_dones", 32'(n_done), 32'd1);
    clr_stats();
    step(1, 1, 2, 1);
    repeat (6) step(1, 0, 0, 1);
    chk("restart_enables", 32'(n_en), 32'd5);
    chk("restart_dones", 32'(n_done), 32'd1);

    // Reset during drain.
    step(1, 1, 4, 1);
    repeat (5) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    clr_stats();
    repeat (6) step(1, 0, 0, 1);
    chk("rst_drain_dones", 32'(n_done), 32'd0);
    chk("rst_drain_enables", 32'(n_en), 32'd0);
    run_op("after_rst", 4, 7, 4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int c;
      case ($urandom_range(0, 5))
        0: c = 0;
        1: c = 64;
        2: c = 100;
        3: c = int'($urandom_range(1, 8));
        4: c = int'($urandom_range(60, 70));
        default: c = int'($urandom_range(0, 2047));
      endcase
      step($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0, c,
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
